// File: rtl/uart_pkt_framer.sv
// uart_pkt_framer: wraps a payload byte stream into a packet for a UART transmitter.
// Each packet is a 4-byte header followed by the payload:
//   header = {opcode, ReservedByte, len[7:0], len[15:8]}
//   payload = len - 4 bytes, passed through combinationally (none when len <= 4).
// The len field is the total packet length, header included.
//
// Ports
//   clk_i, reset_ni                     clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o             packet command handshake
//   cmd_opcode_i, cmd_len_i             command opcode and total length
//   valid_i/ready_o, data_i             payload byte input stream
//   valid_o/ready_i, data_o             byte stream to the UART transmitter
//   busy_o                              packet in progress (any state but Idle)
//   echo_o                              registered (opcode == OpEcho) for the current packet
module uart_pkt_framer #(
  parameter logic [7:0] ReservedByte = 8'h00,
  parameter logic [7:0] OpEcho       = 8'hEC
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        cmd_valid_i,
  input  logic [7:0]  cmd_opcode_i,
  input  logic [15:0] cmd_len_i,
  output logic        cmd_ready_o,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [7:0]  data_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        echo_o
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StOpcode   = 3'd1,
    StReserved = 3'd2,
    StLenLsb   = 3'd3,
    StLenMsb   = 3'd4,
    StPayload  = 3'd5,
    StDone     = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic        echo_q, echo_d;

  logic [15:0] pay_len;
  logic [15:0] cnt_inc;

  // Only evaluated in Payload, which is entered only when len_q > 4, so no underflow there.
  assign pay_len = len_q - 16'd4;
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    echo_d      = echo_q;
    cmd_ready_o = 1'b0;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    data_o      = 8'h00;
    busy_o      = 1'b1;

    case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) begin
          opcode_d = cmd_opcode_i;
          len_d    = cmd_len_i;
          echo_d   = (cmd_opcode_i == OpEcho);
          cnt_d    = 16'd0;
          state_d  = StOpcode;
        end
      end
      StOpcode: begin
        valid_o = 1'b1;
        data_o  = opcode_q;
        if (ready_i) state_d = StReserved;
      end
      StReserved: begin
        valid_o = 1'b1;
        data_o  = ReservedByte;
        if (ready_i) state_d = StLenLsb;
      end
      StLenLsb: begin
        valid_o = 1'b1;
        data_o  = len_q[7:0];
        if (ready_i) state_d = StLenMsb;
      end
      StLenMsb: begin
        valid_o = 1'b1;
        data_o  = len_q[15:8];
        if (ready_i) state_d = (len_q > 16'd4) ? StPayload : StDone;
      end
      StPayload: begin
        // Straight pass-through; data is forced to zero while nothing is offered.
        valid_o = valid_i;
        data_o  = valid_i ? data_i : 8'h00;
        ready_o = ready_i;
        if (valid_i && ready_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == pay_len) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      opcode_q <= 8'h00;
      len_q    <= 16'h0000;
      cnt_q    <= 16'h0000;
      echo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      echo_q   <= echo_d;
    end
  end

  assign echo_o = echo_q;

endmodule
